// File: rtl/hpdcache_sram_req_ctrl_pkg.sv
// Shared types for the SRAM request controller.
package hpdcache_sram_req_ctrl_pkg;

   typedef enum logic {StInit, StReady} state_e;

endpackage

// File: rtl/hpdcache_sram_req_ctrl_if.sv
// Request/response and SRAM command bundle of the SRAM request controller.
interface hpdcache_sram_req_ctrl_if #(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned NDATA     = 1
);
   localparam int unsigned DW = NDATA * DATA_SIZE;
   localparam int unsigned BW = DW / 8;

   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 req_we_i;
   logic [ADDR_SIZE-1:0] req_addr_i;
   logic [DW-1:0]        req_wdata_i;
   logic [BW-1:0]        req_wbe_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [DW-1:0]        rsp_rdata_o;
   logic                 init_done_o;
   logic                 sram_cs_o;
   logic                 sram_we_o;
   logic [ADDR_SIZE-1:0] sram_addr_o;
   logic [DW-1:0]        sram_wdata_o;
   logic [BW-1:0]        sram_wbyteenable_o;
   logic [DW-1:0]        sram_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wbe_i, rsp_ready_i,
             sram_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o, sram_cs_o, sram_we_o,
             sram_addr_o, sram_wdata_o, sram_wbyteenable_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wbe_i, rsp_ready_i,
             sram_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o, sram_cs_o, sram_we_o,
             sram_addr_o, sram_wdata_o, sram_wbyteenable_o
   );

endinterface

// File: rtl/hpdcache_sram_rsp_hold.sv
// Read response staging: presents SRAM data the cycle after a read and holds it
// in a local register while the consumer stalls.
module hpdcache_sram_rsp_hold #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rd_accept_i,
   input  logic             rsp_ready_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic             rsp_valid_o,
   output logic [WIDTH-1:0] rsp_rdata_o
);

   logic             rd_pend_q;
   logic             hold_vld_q;
   logic [WIDTH-1:0] hold_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_pend_q  <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         rd_pend_q <= rd_accept_i;
         // SRAM output is only valid one cycle; snapshot it if the consumer stalls.
         if (rsp_ready_i) begin
            hold_vld_q <= 1'b0;
         end else if (rd_pend_q) begin
            hold_vld_q <= 1'b1;
            hold_q     <= rdata_i;
         end
      end
   end

   assign rsp_valid_o = rd_pend_q | hold_vld_q;
   assign rsp_rdata_o = hold_vld_q ? hold_q : rdata_i;

endmodule

// File: rtl/hpdcache_sram_req_ctrl.sv
// 1RW SRAM request controller with single-slot read response buffering.
// Define HPDCACHE_SRAM_REQ_CTRL_INIT_EN to zero the array after reset.
module hpdcache_sram_req_ctrl
   import hpdcache_sram_req_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned DEPTH     = 2**ADDR_SIZE,
   parameter int unsigned NDATA     = 1
) (
   input logic                     clk_i,
   input logic                     rst_i,
   hpdcache_sram_req_ctrl_if.slave bus
);

   localparam int unsigned DW = NDATA * DATA_SIZE;

   logic                 init_done;
   logic                 sweep;
   logic [ADDR_SIZE-1:0] sweep_addr;
   logic                 req_ready;
   logic                 req_fire;
   logic                 rsp_valid;

`ifdef HPDCACHE_SRAM_REQ_CTRL_INIT_EN
   // One spare bit so a full 2**ADDR_SIZE sweep ends without wrapping.
   localparam int unsigned     CntW    = ADDR_SIZE + 1;
   localparam logic [CntW-1:0] LastRow = CntW'(DEPTH - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == StInit) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LastRow) state_d = StReady;
      end
   end

   always_comb begin
      init_done  = (state_q == StReady);
      sweep      = (state_q == StInit);
      sweep_addr = cnt_q[ADDR_SIZE-1:0];
   end
`else
   assign init_done  = 1'b1;
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
`endif

   assign req_ready = init_done & (~rsp_valid | bus.rsp_ready_i);
   assign req_fire  = bus.req_valid_i & req_ready;

   assign bus.req_ready_o = req_ready;
   assign bus.init_done_o = init_done;
   assign bus.rsp_valid_o = rsp_valid;

   always_comb begin
      bus.sram_cs_o          = 1'b0;
      bus.sram_we_o          = 1'b0;
      bus.sram_addr_o        = '0;
      bus.sram_wdata_o       = '0;
      bus.sram_wbyteenable_o = '0;
      if (sweep) begin
         bus.sram_cs_o          = 1'b1;
         bus.sram_we_o          = 1'b1;
         bus.sram_addr_o        = sweep_addr;
         bus.sram_wbyteenable_o = '1;
      end else if (req_fire) begin
         bus.sram_cs_o          = 1'b1;
         bus.sram_we_o          = bus.req_we_i;
         bus.sram_addr_o        = bus.req_addr_i;
         bus.sram_wdata_o       = bus.req_wdata_i;
         bus.sram_wbyteenable_o = bus.req_wbe_i;
      end
   end

   hpdcache_sram_rsp_hold #(
      .WIDTH (DW)
   ) i_rsp_hold (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_accept_i (req_fire & ~bus.req_we_i),
      .rsp_ready_i (bus.rsp_ready_i),
      .rdata_i     (bus.sram_rdata_i),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (bus.rsp_rdata_o)
   );

endmodule

// File: tb/tb_hpdcache_sram_req_ctrl.sv
// Self-checking bench: controller paired with a behavioural 1RW byte-enable SRAM,
// checked against a response-slot / memory-array reference model.
module tb_hpdcache_sram_req_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 64;

`ifdef HPDCACHE_SRAM_REQ_CTRL_INIT_EN
   localparam logic RdyInRst = 1'b0;
`else
   localparam logic RdyInRst = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hpdcache_sram_req_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .NDATA(1)) bus ();

   hpdcache_sram_req_ctrl #(
      .ADDR_SIZE (AW),
      .DATA_SIZE (DW),
      .DEPTH     (16),
      .NDATA     (1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Behavioural SRAM: rdata reflects the row touched by the latest cs cycle.
   logic [63:0] sram_mem [16];
   always @(posedge clk) begin
      if (bus.sram_cs_o) begin
         if (bus.sram_we_o) begin
            sram_mem[bus.sram_addr_o] <= merge(sram_mem[bus.sram_addr_o], bus.sram_wdata_o,
                                               bus.sram_wbyteenable_o);
            bus.sram_rdata_i <= merge(sram_mem[bus.sram_addr_o], bus.sram_wdata_o,
                                      bus.sram_wbyteenable_o);
         end else begin
            bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: expected array contents plus one outstanding response slot.
   logic [63:0] ref_mem [16];
   logic        m_out = 1'b0;
   logic [63:0] m_data = '0;

   logic        o_ready, o_rvld, o_done, o_cs, o_we;
   logic [3:0]  o_addr;
   logic [63:0] o_rdata, o_wdata;
   logic [7:0]  o_wbe;
   logic        e_ready, e_rvld, e_fire;
   logic [63:0] e_rdata;

   task automatic sample();
      o_ready = bus.req_ready_o;
      o_rvld  = bus.rsp_valid_o;
      o_done  = bus.init_done_o;
      o_cs    = bus.sram_cs_o;
      o_we    = bus.sram_we_o;
      o_addr  = bus.sram_addr_o;
      o_rdata = bus.rsp_rdata_o;
      o_wdata = bus.sram_wdata_o;
      o_wbe   = bus.sram_wbyteenable_o;
   endtask

   // Drive one cycle, snapshot outputs before the edge, then advance the model.
   task automatic cyc(input logic v, input logic we, input logic [3:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic rr);
      bus.req_valid_i = v;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wdata_i = d;
      bus.req_wbe_i   = be;
      bus.rsp_ready_i = rr;
      #1;
      sample();
      e_ready = !m_out || rr;
      e_rvld  = m_out;
      e_rdata = m_data;
      e_fire  = v && e_ready;
      @(posedge clk);
      #1;
      if (e_fire && we) ref_mem[a] = merge(ref_mem[a], d, be);
      if (e_fire && !we) begin
         m_out  = 1'b1;
         m_data = ref_mem[a];
      end else if (rr) begin
         m_out = 1'b0;
      end
   endtask

   task automatic idle();
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.req_wbe_i   = '0;
      bus.rsp_ready_i = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      sample();
      n_cmp++;
      if (o_rvld !== 1'b0) begin
         n_err++; $display("FAIL reset_rsp_valid got %b want 0", o_rvld);
      end
      n_cmp++;
      if (o_ready !== RdyInRst) begin
         n_err++; $display("FAIL reset_req_ready got %b want %b", o_ready, RdyInRst);
      end
      n_cmp++;
      if (o_done !== RdyInRst) begin
         n_err++; $display("FAIL reset_init_done got %b want %b", o_done, RdyInRst);
      end
      m_out = 1'b0;
      rst   = 1'b0;
      #1;
   endtask

   task automatic test_init_sweep();
      int cyc_n = 0;
      sample();
`ifdef HPDCACHE_SRAM_REQ_CTRL_INIT_EN
      while (o_done !== 1'b1 && cyc_n < 40) begin
         n_cmp++;
         if (o_cs !== 1'b1 || o_we !== 1'b1 || o_addr !== cyc_n[3:0] || o_wbe !== 8'hFF ||
             o_wdata !== 64'h0 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_row cycle %0d got cs=%b we=%b addr=%0d wbe=%h rdy=%b want row %0d",
                     cyc_n, o_cs, o_we, o_addr, o_wbe, o_ready, cyc_n);
         end
         @(posedge clk);
         #1;
         sample();
         cyc_n++;
      end
      n_cmp++;
      if (cyc_n != 16) begin
         n_err++; $display("FAIL init_cycles got %0d low cycles want 16", cyc_n);
      end
      for (int a = 0; a < 16; a++) ref_mem[a] = '0;
`else
      n_cmp++;
      if (o_done !== 1'b1) begin
         n_err++; $display("FAIL init_done_nomacro got %b want 1", o_done);
      end
      for (int a = 0; a < 16; a++) cyc(1'b1, 1'b1, 4'(a), 64'h0, 8'hFF, 1'b1);
      for (int a = 0; a < 16; a++) ref_mem[a] = '0;
      cyc_n = 16;
`endif
   endtask

   task automatic test_read_zero();
      logic [3:0] addrs [4];
      for (int k = 0; k < 4; k++) addrs[k] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 5; k++) begin
         cyc(k < 4, 1'b0, (k < 4) ? addrs[k % 4] : 4'd0, {$urandom, $urandom}, 8'($urandom),
             1'b1);
         if (k >= 1) begin
            n_cmp++;
            if (o_rvld !== 1'b1 || o_rdata !== 64'h0) begin
               n_err++;
               $display("FAIL read_zero addr %0d got vld=%b data=%h want 1/0", addrs[k-1],
                        o_rvld, o_rdata);
            end
         end
      end
   endtask

   task automatic test_write_read();
      cyc(1'b1, 1'b1, 4'd3, 64'h1122334455667788, 8'h0F, 1'b1);
      n_cmp++;
      if (o_ready !== 1'b1 || o_cs !== 1'b1 || o_we !== 1'b1 || o_addr !== 4'd3 ||
          o_wdata !== 64'h1122334455667788 || o_wbe !== 8'h0F) begin
         n_err++;
         $display("FAIL write_cmd got rdy=%b cs=%b we=%b addr=%0d wd=%h wbe=%h", o_ready, o_cs,
                  o_we, o_addr, o_wdata, o_wbe);
      end
      cyc(1'b1, 1'b0, 4'd3, 64'h0, 8'h00, 1'b1);
      n_cmp++;
      if (o_cs !== 1'b1 || o_we !== 1'b0 || o_addr !== 4'd3 || o_rvld !== 1'b0) begin
         n_err++;
         $display("FAIL read_cmd got cs=%b we=%b addr=%0d vld=%b want 1/0/3/0", o_cs, o_we,
                  o_addr, o_rvld);
      end
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b1);
      n_cmp++;
      if (o_rvld !== 1'b1 || o_rdata !== 64'h0000000055667788) begin
         n_err++;
         $display("FAIL write_read got vld=%b data=%h want 1/0000000055667788", o_rvld, o_rdata);
      end
   endtask

   task automatic test_stall();
      cyc(1'b1, 1'b0, 4'd3, 64'h0, 8'h00, 1'b0);
      n_cmp++;
      if (o_ready !== 1'b1 || o_cs !== 1'b1) begin
         n_err++; $display("FAIL stall_accept got rdy=%b cs=%b want 1/1", o_ready, o_cs);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 8'hFF, 1'b0);
         n_cmp++;
         if (o_ready !== 1'b0 || o_cs !== 1'b0 || o_rvld !== 1'b1 ||
             o_rdata !== 64'h0000000055667788) begin
            n_err++;
            $display("FAIL stall_hold cycle %0d got rdy=%b cs=%b vld=%b data=%h", i, o_ready,
                     o_cs, o_rvld, o_rdata);
         end
      end
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b1);
      n_cmp++;
      if (o_ready !== 1'b1 || o_rvld !== 1'b1 || o_rdata !== 64'h0000000055667788) begin
         n_err++;
         $display("FAIL stall_release got rdy=%b vld=%b data=%h", o_ready, o_rvld, o_rdata);
      end
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b1);
      n_cmp++;
      if (o_rvld !== 1'b0) begin
         n_err++; $display("FAIL stall_drained got vld=%b want 0", o_rvld);
      end
   endtask

   task automatic test_random();
      logic v, we, rr;
      logic [3:0] a;
      logic [63:0] d;
      logic [7:0] be;
      for (int i = 0; i < 300; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         we = 1'($urandom);
         a  = 4'($urandom);
         d  = {$urandom, $urandom};
         be = 8'($urandom);
         rr = ($urandom_range(0, 3) != 0);
         cyc(v, we, a, d, be, rr);
         n_cmp++;
         if (o_ready !== e_ready || o_rvld !== e_rvld) begin
            n_err++;
            $display("FAIL rnd_hs cycle %0d got rdy=%b vld=%b want %b/%b", i, o_ready, o_rvld,
                     e_ready, e_rvld);
         end
         if (e_rvld) begin
            n_cmp++;
            if (o_rdata !== e_rdata) begin
               n_err++; $display("FAIL rnd_data cycle %0d got %h want %h", i, o_rdata, e_rdata);
            end
         end
         n_cmp++;
         if (e_fire) begin
            if (o_cs !== 1'b1 || o_we !== we || o_addr !== a || o_wdata !== d || o_wbe !== be) begin
               n_err++;
               $display("FAIL rnd_cmd cycle %0d got cs=%b we=%b addr=%0d wd=%h wbe=%h", i, o_cs,
                        o_we, o_addr, o_wdata, o_wbe);
            end
         end else if ({o_cs, o_we, o_addr, o_wdata, o_wbe} !== '0) begin
            n_err++;
            $display("FAIL rnd_idle cycle %0d got cs=%b we=%b addr=%0d want all 0", i, o_cs,
                     o_we, o_addr);
         end
      end
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b1);
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      for (int i = 0; i < 17; i++) begin
         cyc(i < 16, 1'b0, 4'(i), 64'h0, 8'h00, 1'b1);
         if (i < 16) begin
            n_cmp++;
            if (o_ready !== 1'b1 || o_cs !== 1'b1 || o_addr !== 4'(i)) begin
               n_err++;
               $display("FAIL b2b_cmd %0d got rdy=%b cs=%b addr=%0d", i, o_ready, o_cs, o_addr);
            end
         end
         if (i >= 1) begin
            n_cmp++;
            if (o_rvld !== 1'b1 || o_rdata !== ref_mem[i-1]) begin
               n_err++;
               $display("FAIL b2b_rsp addr %0d got vld=%b data=%h want %h", i - 1, o_rvld,
                        o_rdata, ref_mem[i-1]);
            end else begin
               seen++;
            end
         end
      end
      n_cmp++;
      if (seen != 16) begin
         n_err++; $display("FAIL b2b_count got %0d want 16", seen);
      end
   endtask

   task automatic test_reset_mid_response();
      cyc(1'b1, 1'b0, 4'd5, 64'h0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b0);
      n_cmp++;
      if (o_rvld !== 1'b1) begin
         n_err++; $display("FAIL rst_rsp_pending got vld=%b want 1", o_rvld);
      end
      rst = 1'b1;
      #1;
      sample();
      m_out = 1'b0;
      n_cmp++;
      if (o_rvld !== 1'b0 || o_ready !== RdyInRst || o_done !== RdyInRst) begin
         n_err++;
         $display("FAIL rst_async got vld=%b rdy=%b done=%b want 0/%b/%b", o_rvld, o_ready,
                  o_done, RdyInRst, RdyInRst);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      test_init_sweep();
      cyc(1'b0, 1'b0, 4'd0, 64'h0, 8'h00, 1'b1);
      n_cmp++;
      if (o_rvld !== 1'b0) begin
         n_err++; $display("FAIL rst_rsp_lost got vld=%b want 0", o_rvld);
      end
   endtask

   task automatic test_reset_mid_sweep();
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
      end
      sample();
`ifdef HPDCACHE_SRAM_REQ_CTRL_INIT_EN
      n_cmp++;
      if (o_cs !== 1'b1 || o_addr !== 4'd7 || o_done !== 1'b0) begin
         n_err++;
         $display("FAIL sweep_row7 got cs=%b addr=%0d done=%b", o_cs, o_addr, o_done);
      end
`else
      n_cmp++;
      if (o_done !== 1'b1 || o_cs !== 1'b0) begin
         n_err++; $display("FAIL ready_after_rst got done=%b cs=%b", o_done, o_cs);
      end
`endif
      rst = 1'b1;
      #1;
      sample();
      n_cmp++;
      if (o_addr !== 4'd0 || o_done !== RdyInRst) begin
         n_err++;
         $display("FAIL sweep_restart got addr=%0d done=%b want 0/%b", o_addr, o_done, RdyInRst);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      test_init_sweep();
      test_read_zero();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sram_rdata_i = '0;
      test_reset();
      test_init_sweep();
      test_read_zero();
      test_write_read();
      test_stall();
      test_random();
      test_back_to_back();
      test_reset_mid_response();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hpdcache_sram_req_ctrl.md
HPDCACHE_SRAM_REQ_CTRL -- requirements
Module: hpdcache_sram_req_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 8, SRAM address width.
REQ-002 Parameter DATA_SIZE, default 64, bits per data word; multiple of 8.
REQ-003 Parameter DEPTH, default 2**ADDR_SIZE, number of SRAM rows.
REQ-004 Parameter NDATA, default 1, data words per row.
REQ-005 clk_i  in  1  the block's only clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_valid_i  in  1  access request valid.
REQ-008 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-009 req_we_i  in  1  1 = write, 0 = read.
REQ-010 req_addr_i  in  ADDR_SIZE  row address.
REQ-011 req_wdata_i  in  NDATA*DATA_SIZE  write data.
REQ-012 req_wbe_i  in  NDATA*DATA_SIZE/8  write byte enables.
REQ-013 rsp_valid_o  out  1  read data valid.
REQ-014 rsp_ready_i  in  1  consumer accepts read data.
REQ-015 rsp_rdata_o  out  NDATA*DATA_SIZE  read data.
REQ-016 init_done_o  out  1  controller accepts requests.
REQ-017 sram_cs_o, sram_we_o  out  1 each  SRAM chip select and write enable.
REQ-018 sram_addr_o  out  ADDR_SIZE;  sram_wdata_o  out  NDATA*DATA_SIZE;  sram_wbyteenable_o  out  NDATA*DATA_SIZE/8  SRAM command fields.
REQ-019 sram_rdata_i  in  NDATA*DATA_SIZE  SRAM read data; valid the cycle after a cs cycle; overwritten by every later cs cycle, including write cycles.

Function
REQ-020 States: INIT and READY.
- INIT: sweeps the array.
- READY: serves requests.
REQ-021 In READY, an accepted request drives the SRAM combinationally in the same cycle: sram_cs_o=1, sram_we_o=req_we_i, and addr/wdata/wbe passed through unchanged.
REQ-022 The SRAM command outputs are 0 in any cycle with no accepted request and no INIT sweep write.
REQ-023 Signal rd_pend_q is set the cycle after an accepted read and cleared otherwise.
REQ-024 Accepted writes produce no response.
REQ-025 rsp_valid_o = rd_pend_q OR hold_vld_q.
REQ-026 rsp_rdata_o = hold_q when hold_vld_q is set; otherwise rsp_rdata_o = sram_rdata_i.
REQ-027 If rd_pend_q=1 and rsp_ready_i=0, the block captures sram_rdata_i into hold_q and sets hold_vld_q.
REQ-028 hold_vld_q clears on any cycle with rsp_ready_i=1.
REQ-029 req_ready_o = init_done_o AND (NOT rsp_valid_o OR rsp_ready_i).
- Consequence: rd_pend_q and hold_vld_q are never both 1.
- Consequence: at most one response is outstanding.
REQ-030 Read latency is exactly 1 cycle from acceptance to rsp_valid_o.
REQ-031 Sustained throughput is 1 access per cycle while rsp_ready_i=1.
REQ-032 A write issued while hold_vld_q=1 does not corrupt rsp_rdata_o.
REQ-033 A read following a write to the same address on the next cycle returns the written bytes.
REQ-034 Sweep counter width is ADDR_SIZE+1 so DEPTH=2**ADDR_SIZE terminates without wrap.

Reset
REQ-035 Asserting rst_i forces, asynchronously:
- state INIT (macro defined) or READY (macro undefined);
- sweep counter 0;
- rd_pend_q=0, hold_vld_q=0, hold_q=0.
REQ-036 rst_i asserted mid-sweep or mid-response discards all progress; any pending response is lost.
REQ-037 Output values while rst_i=1: rsp_valid_o=0; req_ready_o=0 with the macro, 1 without; init_done_o=0 with the macro, 1 without.

Configuration
REQ-038 Macro HPDCACHE_SRAM_REQ_CTRL_INIT_EN defined: INIT writes zeros with all byte enables set to rows 0..DEPTH-1, one row per cycle, then moves to READY.
- INIT takes exactly DEPTH cycles after reset release.
- init_done_o rises on cycle DEPTH+1.
- req_ready_o=0 throughout INIT.
REQ-039 Macro undefined: no INIT state, no sweep counter, READY straight out of reset, array contents undefined.

Structure
REQ-040 A shared package hpdcache_sram_req_ctrl_pkg holds the state enum type (INIT, READY).
REQ-041 The response hold logic is a natural sub-module, hpdcache_sram_rsp_hold, parameterized by the read-data width.

Verification (bench pairs the block with the team's behavioural 1RW byte-enable SRAM, DEPTH=16, NDATA=1, DATA_SIZE=64)
REQ-042 Reset release with the macro defined -> init_done_o low for 16 cycles, high on cycle 17; a read of any address returns 0x0.
REQ-043 Write addr 3 data 0x1122334455667788 wbe 0x0F, then read addr 3 next cycle -> rsp_valid_o one cycle later, data 0x0000000055667788.
REQ-044 Read addr 3 with rsp_ready_i=0 for 4 cycles while req_valid_i is held high with write requests -> req_ready_o=0, data stable at 0x0000000055667788, no SRAM cs until consumed.
REQ-045 Back-to-back reads addr 0..15 with rsp_ready_i=1 -> 16 responses on 16 consecutive cycles, in address order.
REQ-046 rst_i pulse at sweep row 7 -> sweep restarts at row 0; init_done_o rises 16 cycles after release.
